bp_update_queue: RTL and testbench



---
 rtl/bp_update_queue_if.sv | 29 ++
 rtl/bp_update_queue.sv | 91 +++++++++
 tb/tb_bp_update_queue.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_queue_if.sv
// Handshake bundle between the execute-stage producer, the predictor update consumer
// and bp_update_queue. The queue connects through the slave modport.
interface bp_update_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned HIST_W = 8
);
   logic                     en_i;
   logic                     flush_i;
   logic                     push_valid_i;
   logic                     push_ready_o;
   logic [PC_W-1:0]          push_pc_i;
   logic                     push_taken_i;
   logic                     update_en_o;
   logic                     last_taken_o;
   logic [PC_W-1:0]          update_pc_o;
   logic [HIST_W-1:0]        ghr_o;
   logic [$clog2(DEPTH):0]   count_o;

   modport master (
      output en_i, flush_i, push_valid_i, push_pc_i, push_taken_i,
      input  push_ready_o, update_en_o, last_taken_o, update_pc_o, ghr_o, count_o
   );

   modport slave (
      input  en_i, flush_i, push_valid_i, push_pc_i, push_taken_i,
      output push_ready_o, update_en_o, last_taken_o, update_pc_o, ghr_o, count_o
   );
endinterface

// File: rtl/bp_update_queue.sv
// Resolved-branch outcome queue feeding predictor updates and the committed GHR.
// Optional same-cycle bypass of an empty queue: define BPUQ_BYPASS_EN.
module bp_update_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned HIST_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   bp_update_queue_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [CW-1:0]     wr_cnt;
   logic [CW-1:0]     rd_cnt;
   logic [CW-1:0]     count;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [HIST_W-1:0] ghr;
   entry_t            push_entry;
   entry_t            head;
   logic              full;
   logic              nonempty;
   logic              bypass;
   logic              update_en;
   logic              pop;
   logic              push;
   logic              mem_pop;

   // Free-running counters one bit wider than the pointers; their difference is occupancy.
   assign count    = wr_cnt - rd_cnt;
   assign wr_ptr   = wr_cnt[AW-1:0];
   assign rd_ptr   = rd_cnt[AW-1:0];
   assign full     = (count == CW'(DEPTH));
   assign nonempty = (count != '0);

   assign push_entry = '{pc: bus.push_pc_i, taken: bus.push_taken_i};

`ifdef BPUQ_BYPASS_EN
   assign bypass = !nonempty && bus.push_valid_i && !bus.flush_i;
`else
   assign bypass = 1'b0;
`endif

   assign update_en = (nonempty && !bus.flush_i) || bypass;
   assign head      = bypass ? push_entry : mem[rd_ptr];
   assign pop       = update_en && bus.en_i;
   // A bypassed entry that is consumed in the same cycle never touches storage.
   assign mem_pop   = pop && !bypass;
   assign push      = bus.push_valid_i && !full && !bus.flush_i && !(bypass && bus.en_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         ghr    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.flush_i) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_cnt      <= wr_cnt + 1'b1;
         end
         if (mem_pop) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (pop) begin
            ghr <= {ghr[HIST_W-2:0], head.taken};
         end
      end
   end

   assign bus.push_ready_o = !full;
   assign bus.update_en_o  = update_en;
   assign bus.last_taken_o = head.taken;
   assign bus.update_pc_o  = head.pc;
   assign bus.ghr_o        = ghr;
   assign bus.count_o      = count;

endmodule

// File: tb/tb_bp_update_queue.sv
// Self-checking bench for bp_update_queue: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bp_update_queue;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned HIST_W = 8;
`ifdef BPUQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bp_update_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W)) bus ();

   bp_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .HIST_W(HIST_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [PC_W-1:0] pc;
      logic            taken;
   } ent_t;

   typedef struct {
      logic        en;
      logic        pv;
      logic [31:0] pc;
      logic        tk;
      logic        e_upd;
      logic        e_chk;
      logic [31:0] e_pc;
      logic        e_tk;
      int          e_cnt;
      logic        e_rdy;
      logic [7:0]  e_ghr;
   } vec_t;

   ent_t        q[$];
   logic [7:0]  m_ghr;
   int          checks = 0;
   int          errors = 0;
   vec_t        vec[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic fl, input logic pv,
                        input logic [31:0] pc, input logic tk);
      bus.en_i         = en;
      bus.flush_i      = fl;
      bus.push_valid_i = pv;
      bus.push_pc_i    = pc;
      bus.push_taken_i = tk;
   endtask

   // One clock of stimulus: check outputs before the edge against the model, then advance both.
   task automatic cycle(input logic en, input logic fl, input logic pv,
                        input logic [31:0] pc, input logic tk);
      int unsigned n;
      logic byp, exp_upd, do_pop, do_push;
      ent_t h;
      n = q.size();
      h = '{pc: '0, taken: 1'b0};
      drive(en, fl, pv, pc, tk);
      #2;
      byp     = BYP && (n == 0) && pv && !fl;
      exp_upd = ((n != 0) && !fl) || byp;
      chk("update_en", bus.update_en_o, exp_upd);
      chk("push_ready", bus.push_ready_o, n != DEPTH);
      chk("count", bus.count_o, n);
      chk("ghr", bus.ghr_o, m_ghr);
      if (exp_upd) begin
         h = byp ? '{pc: pc, taken: tk} : q[0];
         chk("update_pc", bus.update_pc_o, h.pc);
         chk("last_taken", bus.last_taken_o, h.taken);
      end
      if (fl) begin
         q.delete();
      end else begin
         do_pop  = exp_upd && en;
         do_push = pv && (n != DEPTH) && !(byp && en);
         if (do_pop) begin
            m_ghr = {m_ghr[6:0], h.taken};
            if (!byp) void'(q.pop_front());
         end
         if (do_push) q.push_back('{pc: pc, taken: tk});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Fill to full with en_i low, reject a fifth push, then drain with taken pattern 1,0,1,1.
      vec[0] = '{1'b0, 1'b1, 32'h100, 1'b1, BYP,  BYP,  32'h100, 1'b1, 0, 1'b1, 8'h00};
      vec[1] = '{1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1, 1'b1, 8'h00};
      vec[2] = '{1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 2, 1'b1, 8'h00};
      vec[3] = '{1'b0, 1'b1, 32'h10C, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 3, 1'b1, 8'h00};
      vec[4] = '{1'b0, 1'b1, 32'h110, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4, 1'b0, 8'h00};
      vec[5] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4, 1'b0, 8'h00};
      vec[6] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 3, 1'b1, 8'h01};
      vec[7] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 2, 1'b1, 8'h02};
      vec[8] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 1, 1'b1, 8'h05};
      vec[9] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 0, 1'b1, 8'h0B};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #1;
      chk("reset_count", bus.count_o, 0);
      chk("reset_ready", bus.push_ready_o, 1);
      chk("reset_update_en", bus.update_en_o, 0);
      chk("reset_ghr", bus.ghr_o, 0);
      chk("reset_pc", bus.update_pc_o, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         drive(vec[i].en, 1'b0, vec[i].pv, vec[i].pc, vec[i].tk);
         #2;
         chk($sformatf("vec%0d_update_en", i), bus.update_en_o, vec[i].e_upd);
         chk($sformatf("vec%0d_count", i), bus.count_o, vec[i].e_cnt);
         chk($sformatf("vec%0d_ready", i), bus.push_ready_o, vec[i].e_rdy);
         chk($sformatf("vec%0d_ghr", i), bus.ghr_o, vec[i].e_ghr);
         if (vec[i].e_chk) begin
            chk($sformatf("vec%0d_pc", i), bus.update_pc_o, vec[i].e_pc);
            chk($sformatf("vec%0d_taken", i), bus.last_taken_o, vec[i].e_tk);
         end
         @(posedge clk);
         #1;
      end

      // Reset mid-operation with two entries queued and a non-zero history.
      q.delete();
      m_ghr = 8'h0B;
      cycle(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'h504, 1'b1);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_count", bus.count_o, 0);
      chk("midrst_update_en", bus.update_en_o, 0);
      chk("midrst_ghr", bus.ghr_o, 0);
      chk("midrst_ready", bus.push_ready_o, 1);
      chk("midrst_pc", bus.update_pc_o, 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      m_ghr = '0;

      // Steady push and pop at count 2; 7 pushes into 4 slots exercise pointer wrap.
      cycle(1'b0, 1'b0, 1'b1, 32'h600, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 32'h604, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 32'h608 + 32'(4 * i), 1'(i % 2));
         chk($sformatf("steady%0d_count", i), bus.count_o, 2);
      end
      repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);

      // Shift in 0,1,0,1,1,0,1,0 so the committed history ends at 8'h5A.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] pat;
         pat = 8'h5A;
         cycle(1'b1, 1'b0, 1'b1, 32'h700 + 32'(4 * i), pat[7 - i]);
      end
      repeat (2) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      chk("ghr_5a", bus.ghr_o, 8'h5A);

      // Flush with three queued and a push in the flush cycle.
      cycle(1'b0, 1'b0, 1'b1, 32'h800, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 32'h804, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'h808, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 32'h80C, 1'b1);
      #1;
      chk("flush_update_en", bus.update_en_o, 0);
      chk("flush_count_before", bus.count_o, 3);
      cycle(1'b1, 1'b1, 1'b1, 32'h80C, 1'b1);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
      #2;
      chk("flush_count_after", bus.count_o, 0);
      chk("flush_ghr_kept", bus.ghr_o, 8'h5A);
      chk("flush_entry_gone", bus.update_en_o, 0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);

      // Empty-queue push with en_i high: bypass consumes it, otherwise it appears a cycle later.
      cycle(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
      drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
      #2;
`ifdef BPUQ_BYPASS_EN
      chk("bypass_count", bus.count_o, 0);
      chk("bypass_ghr0", bus.ghr_o[0], 1);
      chk("bypass_update_en_after", bus.update_en_o, 0);
`else
      chk("nobypass_update_en", bus.update_en_o, 1);
      chk("nobypass_pc", bus.update_pc_o, 32'h200);
      chk("nobypass_count", bus.count_o, 1);
`endif
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 2) != 0, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
